// File: rtl/cube_pkg.sv
// Shared widths, state encodings and voxel address helpers for the 8x8x8 cube scanner.
package cube_pkg;
  localparam int ADDR_W = 9;
  localparam int CRD_W  = 3;
  localparam int DCRD_W = 4;
  localparam int CW_DEF = 3;
  localparam int NVOX   = 512;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ON, S_OFF} scan_st_t;
  typedef enum logic {C_IDLE, C_RUN} clr_st_t;

  // Address layout is {z,y,x} so a plain increment scans x fastest.
  typedef struct packed {
    logic [CRD_W-1:0] z;
    logic [CRD_W-1:0] y;
    logic [CRD_W-1:0] x;
  } vox_t;

  function automatic logic [ADDR_W-1:0] vox_pack(input logic [CRD_W-1:0] x,
                                                 input logic [CRD_W-1:0] y,
                                                 input logic [CRD_W-1:0] z);
    return {z, y, x};
  endfunction

  function automatic vox_t vox_unpack(input logic [ADDR_W-1:0] a);
    return vox_t'(a);
  endfunction
endpackage

// File: rtl/cube_frame_ram.sv
// Dual-bank 512 x CW frame store: one write port, one registered read port.
module cube_frame_ram
  import cube_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_we,
  input  logic              i_wbank,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [CW-1:0]     i_wdata,
  input  logic              i_re,
  input  logic              i_rbank,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [CW-1:0]     o_rdata
);
  logic [CW-1:0] r_mem [2*NVOX];

  always_ff @(posedge clk)
    if (i_we) r_mem[{i_wbank, i_waddr}] <= i_wdata;

  // The read register doubles as the displayed colour, so it clears on reset.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn)   o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[{i_rbank, i_raddr}];
endmodule

// File: rtl/cube_scan_ctrl.sv
// Voxel scanner for the LED cube: scans the front bank with fixed dwell/blank
// timing while writers and the clear engine own the back bank.
module cube_scan_ctrl
  import cube_pkg::*;
#(
  parameter int DWELL = 16,
  parameter int BLANK = 2,
  parameter int CW    = CW_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic              wr_en,
  input  logic [CRD_W-1:0]  wr_x,
  input  logic [CRD_W-1:0]  wr_y,
  input  logic [CRD_W-1:0]  wr_z,
  input  logic [CW-1:0]     wr_color,
  input  logic              clr_req,
  input  logic              swap_req,
  output logic              busy,
  output logic              swap_done,
  output logic              frame_start,
  output logic [DCRD_W-1:0] oX,
  output logic [DCRD_W-1:0] oY,
  output logic [DCRD_W-1:0] oZ,
  output logic [3:0]        color,
  output logic              enable
);
  localparam int CNT_W = $clog2(DWELL + BLANK + 1) + 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

  scan_st_t          r_state;
  clr_st_t           r_cstate;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_caddr;
  logic              r_front;
  logic              r_pend;
  logic              r_swap_done;
  vox_t              r_vox;

  logic              w_busy;
  logic              w_pend_any;
  logic              w_vox_end;
  logic              w_wrap;
  logic              w_swap_now;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [CW-1:0]     w_wdata;
  logic [CW-1:0]     w_rdata;

  assign w_busy     = (r_cstate == C_RUN);
  assign w_pend_any = r_pend | swap_req;
  assign w_vox_end  = ((r_state == S_ON) && (r_cnt == DWELL_LAST) && (BLANK == 0)) ||
                      ((r_state == S_OFF) && (r_cnt == BLANK_LAST));
  assign w_wrap     = w_vox_end && run && (r_addr == ADDR_W'(NVOX - 1));
  // A swap never lands while the back bank is being cleared; it stays pending.
  assign w_swap_now = w_pend_any && !w_busy && (w_wrap || (r_state == S_IDLE));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_vox       <= '0;
      r_front     <= 1'b0;
      r_pend      <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_pend      <= w_pend_any & ~w_swap_now;
      r_swap_done <= w_swap_now;
      if (w_swap_now) r_front <= ~r_front;
      case (r_state)
        S_IDLE: if (run) begin
          r_state <= S_FETCH;
          r_addr  <= '0;
        end
        S_FETCH: begin
          r_state <= S_ON;
          r_cnt   <= '0;
          r_vox   <= vox_unpack(r_addr);
        end
        S_ON:
          if (r_cnt != DWELL_LAST) r_cnt <= r_cnt + 1'b1;
          else if (BLANK > 0) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
          end
        S_OFF: if (r_cnt != BLANK_LAST) r_cnt <= r_cnt + 1'b1;
        default: r_state <= S_IDLE;
      endcase
      // run is only sampled at voxel end so a voxel is never cut short.
      if (w_vox_end) begin
        if (run) begin
          r_state <= S_FETCH;
          r_addr  <= r_addr + 1'b1;
        end else begin
          r_state <= S_IDLE;
          r_addr  <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cstate <= C_IDLE;
      r_caddr  <= '0;
    end else if (r_cstate == C_IDLE) begin
      if (clr_req) begin
        r_cstate <= C_RUN;
        r_caddr  <= '0;
      end
    end else begin
      r_caddr <= r_caddr + 1'b1;
      if (r_caddr == ADDR_W'(NVOX - 1)) r_cstate <= C_IDLE;
    end
  end

  assign w_we    = w_busy | wr_en;
  assign w_waddr = w_busy ? r_caddr : vox_pack(wr_x, wr_y, wr_z);
  assign w_wdata = w_busy ? '0 : wr_color;

  cube_frame_ram #(.CW(CW)) u_ram (
    .clk     (clk),
    .resetn  (resetn),
    .i_we    (w_we),
    .i_wbank (~r_front),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (r_state == S_FETCH),
    .i_rbank (r_front),
    .i_raddr (r_addr),
    .o_rdata (w_rdata)
  );

  assign busy        = w_busy;
  assign swap_done   = r_swap_done;
  assign frame_start = (r_state == S_FETCH) && (r_addr == '0);
  assign oX          = {1'b0, r_vox.x};
  assign oY          = {1'b0, r_vox.y};
  assign oZ          = {1'b0, r_vox.z};
  assign color       = 4'(w_rdata);
  assign enable      = (r_state == S_ON) && (w_rdata != '0);
endmodule

// File: doc/cube_scan_ctrl.md
Name: cube_scan_ctrl

Overview:
Upstream scan engine for the 8x8x8 LED cube display driver. Holds a double-buffered 512-voxel colour frame. Game/animation logic writes the back buffer while the front buffer is scanned one voxel at a time. Each voxel is presented to the display driver as coordinates, colour and enable, with fixed dwell and blanking times so every voxel gets uniform brightness.

Parameters:
DWELL, 16, cycles enable is held per lit voxel (>=1)
BLANK, 2, enable-low guard cycles after each dwell (>=0)
CW, 3, colour width; 0 = voxel off

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
run  in  1  level; 1 = scanning permitted
wr_en  in  1  write one voxel into back buffer
wr_x, wr_y, wr_z  in  3 each  write coordinates
wr_color  in  CW  write colour
clr_req  in  1  pulse; zero entire back buffer
swap_req  in  1  pulse; exchange front/back at next frame boundary
busy  out  1  high while a clear is in progress
swap_done  out  1  one-cycle pulse when the swap takes effect
frame_start  out  1  one-cycle pulse on fetch of voxel (0,0,0)
oX, oY, oZ  out  4 each  voxel coordinate to display, bit 3 always 0
color  out  4  zero-extended colour to display
enable  out  1  display strobe

Behaviour:
- Reset (async, resetn=0): state IDLE, scan address 0, front bank 0, swap pending 0, busy 0. All outputs 0. Memory contents not reset.
- Memory: two banks of 512 x CW, address {z,y,x}; 1-cycle synchronous read; scanner reads front, writers write back.
- FSM states: IDLE, FETCH, ON, OFF, CLEAR (the clear engine runs in parallel; CLEAR is its own 2-state machine: CIDLE/CRUN).
- IDLE: enable=0. When run=1, go to FETCH with address 0.
- FETCH (1 cycle): present read address. frame_start=1 if address=0. enable=0.
- ON (DWELL cycles): on entry, register oX/oY/oZ = address fields and color = read data. enable = (color != 0), held constant.
- OFF (BLANK cycles; skipped if BLANK=0): enable=0, coordinates/colour hold.
- End of voxel: increment address, x fastest, then y, then z. If run=0, go to IDLE and reset address to 0. Otherwise go to FETCH.
- Voxel period = 1 + DWELL + BLANK cycles. Frame = 512 periods.
- Swap: swap_req sets pending (sticky; repeat requests merge). When address wraps 511->0 with pending=1:
  - toggle front bank,
  - clear pending,
  - swap_done=1 for that cycle.
  - The next FETCH reads the new front.
- Swap while IDLE: applies immediately on the next cycle, with swap_done.
- Clear: clr_req while busy=0 starts CRUN. Writes zero to back addresses 0..511, one per cycle. busy=1 throughout, for exactly 512 cycles.
  - clr_req while busy is ignored.
  - wr_en during busy is ignored.
  - A swap due during busy is deferred (pending kept) until the next frame boundary after busy falls.
- wr_en with busy=0 writes on the same cycle. Write and scan never collide, since they use different banks.
- wr_en and clr_req in the same cycle: the write lands, then the clear starts next cycle.
- run drop mid-voxel: the current voxel completes (including OFF), then IDLE.

Decomposition:
- Shared package cube_pkg: voxel address width 9, coordinate width 3, display coordinate width 4, CW default, address-pack/unpack function.
- One sub-module: cube_frame_ram, a dual-bank 512xCW RAM with one write port and one registered read port, bank-select inputs.

Test Plan:
1. DWELL=4, BLANK=1. Write (1,0,0)=5 into back, swap_req, run=1 -> swap_done within one frame. Voxel 1 shows oX=1, color=5, enable high 4 cycles. Period is 6 cycles. enable low on all colour-0 voxels.
2. Full frame with run=1 -> frame_start every 512*6=3072 cycles. Address sequence (7,0,0)->(0,1,0) and (7,7,7)->(0,0,0).
3. swap_req mid-frame -> front unchanged until wrap. swap_done at the wrap cycle only. Two requests in one frame -> one swap.
4. clr_req -> busy high exactly 512 cycles. wr_en during busy is dropped. After swap, all voxels read 0 and enable never rises.
5. Deassert run during ON of voxel 10 -> voxel 10 completes (ON+OFF), enable=0, IDLE. Reassert -> restart at (0,0,0) with frame_start.
6. Assert resetn=0 mid-ON -> enable, oX/oY/oZ, color and busy go to 0 immediately, without waiting for clk. Scan restarts at address 0.
